// File: rtl/alu_top.sv
// Registered 32-bit MIPS-style execute-stage ALU with built-in ALU-control decode.
// Result, zero and illegal are updated every cycle from opcode/func_field/A/B.
module alu_top #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_LUI
  } alu_op_e;

  alu_op_e          op;
  logic             illegal_next;
  logic [WIDTH-1:0] result_next;
  logic [4:0]       shamt;
  logic             lt_signed;
  logic             lt_unsigned;

  assign shamt       = A[4:0];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;

  always_comb begin
    op           = OP_ADD;
    illegal_next = 1'b0;
    case (opcode)
      6'h00: begin
        case (func_field)
          6'h20, 6'h21: op = OP_ADD;
          6'h22, 6'h23: op = OP_SUB;
          6'h24:        op = OP_AND;
          6'h25:        op = OP_OR;
          6'h26:        op = OP_XOR;
          6'h27:        op = OP_NOR;
          6'h2A:        op = OP_SLT;
          6'h2B:        op = OP_SLTU;
          6'h04:        op = OP_SLL;
          6'h06:        op = OP_SRL;
          6'h07:        op = OP_SRA;
          default:      illegal_next = 1'b1;
        endcase
      end
      6'h23, 6'h2B, 6'h08, 6'h09: op = OP_ADD;
      6'h04, 6'h05:               op = OP_SUB;
      6'h0A:                      op = OP_SLT;
      6'h0B:                      op = OP_SLTU;
      6'h0C:                      op = OP_AND;
      6'h0D:                      op = OP_OR;
      6'h0E:                      op = OP_XOR;
      6'h0F:                      op = OP_LUI;
      default:                    illegal_next = 1'b1;
    endcase
  end

  always_comb begin
    result_next = '0;
    if (!illegal_next) begin
      case (op)
        OP_ADD:  result_next = A + B;
        OP_SUB:  result_next = A - B;
        OP_AND:  result_next = A & B;
        OP_OR:   result_next = A | B;
        OP_XOR:  result_next = A ^ B;
        OP_NOR:  result_next = ~(A | B);
        OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
        OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
        OP_SLL:  result_next = B << shamt;
        OP_SRL:  result_next = B >> shamt;
        OP_SRA:  result_next = $signed(B) >>> shamt;
        OP_LUI:  result_next = B << 16;
        default: result_next = '0;
      endcase
    end
  end

  // zero derives from result_next so it always agrees with the registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      result  <= result_next;
      zero    <= (result_next == '0);
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Directed-vector bench for alu_top: the driver pushes hand-computed expectations
// into a scoreboard queue, and a monitor pops and compares one cycle later.
module tb_alu_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  func_field = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        z;
    logic        il;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  alu_top #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .func_field (func_field),
    .A          (A),
    .B          (B),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] er, input logic ez, input logic eil);
    tests_run++;
    if (result !== er || zero !== ez || illegal !== eil) begin
      tests_failed++;
      $display("FAIL %s: got result=%h zero=%b illegal=%b, expected result=%h zero=%b illegal=%b",
               name, result, zero, illegal, er, ez, eil);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    opcode     = op;
    func_field = fn;
    A          = a;
    B          = b;
  endtask

  task automatic push(input string name, input logic [31:0] r, input logic il);
    exp_t e;
    e.name = name;
    e.r    = r;
    e.z    = (r == 32'h0);
    e.il   = il;
    sb.push_back(e);
  endtask

  task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic il);
    @(negedge clk);
    drive(op, fn, a, b);
    push(name, r, il);
  endtask

  // Monitor: outputs for the inputs captured at a rising edge are checked 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.r, e.z, e.il);
      end
    end
  end

  initial begin
    drive(6'h00, 6'h20, 32'h2222, 32'h1111);
    #1 rst_n = 1'b0;
    #2 check("reset_no_clock", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("reset_held", 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    push("first_after_reset", 32'h3333, 1'b0);

    issue("add",        6'h00, 6'h20, 32'h2222,     32'h1111,     32'h3333,     1'b0);
    issue("and",        6'h00, 6'h24, 32'h2222,     32'h1111,     32'h0,        1'b0);
    issue("lw",         6'h23, 6'h00, 32'h2222,     32'h1111,     32'h3333,     1'b0);
    issue("beq_eq",     6'h04, 6'h00, 32'h5555,     32'h5555,     32'h0,        1'b0);
    issue("beq_ne",     6'h04, 6'h00, 32'h5555,     32'h5554,     32'h1,        1'b0);
    issue("slt_pos",    6'h00, 6'h2A, 32'h1111,     32'h2222,     32'h1,        1'b0);
    issue("slt_neg",    6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h1,        1'b0);
    issue("sltu_big",   6'h00, 6'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0);
    issue("sltu_small", 6'h00, 6'h2B, 32'h00000001, 32'hFFFFFFFF, 32'h1,        1'b0);
    issue("add_wrap",   6'h00, 6'h20, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0);
    issue("addu_ovf",   6'h00, 6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
    issue("sub_wrap",   6'h00, 6'h22, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0);
    issue("subu",       6'h00, 6'h23, 32'h10,       32'h3,        32'hD,        1'b0);
    issue("or",         6'h00, 6'h25, 32'h00F0,     32'h0F00,     32'h0FF0,     1'b0);
    issue("xor",        6'h00, 6'h26, 32'hFF00,     32'h0FF0,     32'hF0F0,     1'b0);
    issue("nor",        6'h00, 6'h27, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0);
    issue("srav_neg",   6'h00, 6'h07, 32'd31,       32'h80000000, 32'hFFFFFFFF, 1'b0);
    issue("srlv",       6'h00, 6'h06, 32'd31,       32'h80000000, 32'h00000001, 1'b0);
    issue("srav_pos",   6'h00, 6'h07, 32'd1,        32'h40000000, 32'h20000000, 1'b0);
    issue("srav_sh0",   6'h00, 6'h07, 32'h20,       32'h80000000, 32'h80000000, 1'b0);
    issue("sllv_low5",  6'h00, 6'h04, 32'h24,       32'h1,        32'h10,       1'b0);
    issue("lui",        6'h0F, 6'h00, 32'hABCD,     32'h1234,     32'h12340000, 1'b0);
    issue("addi_fnign", 6'h08, 6'h22, 32'h7,        32'h8,        32'hF,        1'b0);
    issue("addiu",      6'h09, 6'h00, 32'h20,       32'h5,        32'h25,       1'b0);
    issue("sw",         6'h2B, 6'h00, 32'h100,      32'h4,        32'h104,      1'b0);
    issue("bne",        6'h05, 6'h00, 32'h9,        32'h4,        32'h5,        1'b0);
    issue("slti",       6'h0A, 6'h00, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b0);
    issue("sltiu",      6'h0B, 6'h00, 32'h1,        32'hFFFFFFFF, 32'h1,        1'b0);
    issue("andi",       6'h0C, 6'h00, 32'hFF0F,     32'h0FF0,     32'h0F00,     1'b0);
    issue("ori",        6'h0D, 6'h00, 32'hF000,     32'h000F,     32'hF00F,     1'b0);
    issue("xori",       6'h0E, 6'h00, 32'hFFFF,     32'h00FF,     32'hFF00,     1'b0);
    issue("ill_opcode", 6'h3F, 6'h20, 32'h2222,     32'h1111,     32'h0,        1'b1);
    issue("ill_funct",  6'h00, 6'h3F, 32'h2222,     32'h1111,     32'h0,        1'b1);
    issue("legal_again",6'h00, 6'h20, 32'h1,        32'h2,        32'h3,        1'b0);

    // Reset asserted between edges during an ADD stream must clear outputs at once
    issue("stream_add1", 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h3333, 1'b0);
    issue("stream_add2", 6'h00, 6'h20, 32'h2000, 32'h0002, 32'h2002, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1 check("async_reset_mid", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("reset_discard", 32'h0, 1'b1, 1'b0);
    drive(6'h00, 6'h22, 32'h50, 32'h8);
    rst_n = 1'b1;
    push("post_reset_sub", 32'h48, 1'b0);

    begin
      int unsigned waited = 0;
      while (sb.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      #2;
      if (sb.size() > 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- Registered 32-bit MIPS-style ALU with built-in ALU-control decode.
- Takes the instruction opcode and function field plus two operands, selects the operation internally, and registers the result and zero flag.
- Sits in the execute stage. A and B come from the register file or an immediate path, and the immediate is already extended upstream.
- zero feeds the branch-decision logic.

Parameters:
- WIDTH, 32, operand and result width in bits (only 32 is required to be supported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction opcode field [31:26]
- func_field  input  6  R-type function field [5:0]; ignored when opcode != 0
- A  input  32  operand A (rs)
- B  input  32  operand B (rt or extended immediate)
- result  output  32  registered ALU result
- zero  output  1  registered; 1 when the registered result equals 0
- illegal  output  1  registered; 1 when the opcode/funct pair is unsupported

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - result = 0, zero = 1, illegal = 0.
  - Release is synchronous to the next rising clk edge.
- Latency is 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until the next edge.
- There is no handshake: one operation is evaluated every cycle.
- Decode for opcode 0x00 (R-type), by func_field:
  - 0x20 ADD: A+B
  - 0x21 ADDU: A+B
  - 0x22 SUB: A-B
  - 0x23 SUBU: A-B
  - 0x24 AND: A&B
  - 0x25 OR: A|B
  - 0x26 XOR: A^B
  - 0x27 NOR: ~(A|B)
  - 0x2A SLT: signed A<B ? 1 : 0
  - 0x2B SLTU: unsigned A<B ? 1 : 0
  - 0x04 SLLV: B << A[4:0]
  - 0x06 SRLV: B >> A[4:0], logical
  - 0x07 SRAV: B >>> A[4:0], arithmetic
- Decode for non-zero opcodes:
  - 0x23 LW, 0x2B SW, 0x08 ADDI, 0x09 ADDIU: A+B (address or sum)
  - 0x04 BEQ, 0x05 BNE: A-B (the branch unit uses zero)
  - 0x0A SLTI: signed compare, as SLT
  - 0x0B SLTIU: unsigned compare, as SLTU
  - 0x0C ANDI: A&B
  - 0x0D ORI: A|B
  - 0x0E XORI: A^B
  - 0x0F LUI: B << 16
- Any other opcode, or any other funct under opcode 0: result = 0, zero = 1, illegal = 1 for that cycle.
- Arithmetic is modulo 2^32 and never traps. Signed overflow is not flagged; ADD and ADDU give identical results.
- SLT/SLTU results are zero-extended to 32 bits (0x00000001 or 0x00000000).
- Only the low 5 bits of A are used as the shift amount; shift amounts 0..31 are valid, and 0 passes B through.
- zero is computed from the same next-state value as result, so zero == (result == 0) holds in every cycle, including reset.
- If reset asserts mid-operation, the in-flight result is discarded. The first post-reset output reflects the inputs sampled at the first rising edge after release.

Test Plan:
- Hold rst_n=0 with A=0x2222, B=0x1111, ADD -> result=0, zero=1, illegal=0, with no clock edges required. Release rst_n, then at the next edge: result=0x00003333, zero=0.
- A=0x2222, B=0x1111, in consecutive cycles:
  - ADD (0x00/0x20) -> 0x3333, zero 0
  - AND (0x00/0x24) -> 0x0000, zero 1
  - LW (0x23) -> 0x3333, zero 0
- Branch compare:
  - BEQ (0x04) with A=B=0x5555 -> result 0, zero 1
  - BEQ with A=0x5555, B=0x5554 -> result 1, zero 0
- Set-less-than:
  - SLT with A=0x1111, B=0x2222 -> 1
  - SLT with A=0xFFFFFFFF, B=0x00000001 -> 1
  - SLTU with A=0xFFFFFFFF, B=0x00000001 -> 0, zero 1
- Wrap and shifts:
  - ADD 0xFFFFFFFF+1 -> 0, zero 1, no trap
  - SUB 0-1 -> 0xFFFFFFFF
  - SRAV with B=0x80000000, A=31 -> 0xFFFFFFFF
  - SRLV with the same operands -> 0x00000001
  - LUI with B=0x1234 -> 0x12340000
- Illegal and reset:
  - opcode 0x3F -> result 0, zero 1, illegal 1
  - opcode 0, funct 0x3F -> same response
  - Assert rst_n between edges during an ADD stream -> outputs clear immediately, with no waiting for clk.
